io_port_component: RTL
======================

# io_port_component

Host-side I/O port for the 16-bit pipelined core: the far end of the core's `read_in`/`write_out` pins. Buffers words a host or testbench pushes toward the core in an input FIFO, presented on `read_in`. Captures words the core emits on `write_out` into an output FIFO that the host drains with a valid/ready handshake. Exports full/empty status so the core's hazard logic can stall on I/O.

## Interface
Parameters:
- `WIDTH`, 16, data word width; matches the core datapath.
- `DEPTH`, 4, entries per FIFO; power of two, ≥2.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `host_in_data`  in  WIDTH  word from host toward core.
- `host_in_valid`  in  1  host_in_data valid.
- `host_in_ready`  out  1  input FIFO can accept a word.
- `read_in`  out  WIDTH  head of input FIFO, to core `read_in`; 0 when empty.
- `cpu_rd`  in  1  core consumes the `read_in` word this cycle.
- `in_empty`  out  1  input FIFO empty; core stalls on an I/O read.
- `write_out`  in  WIDTH  word from core `write_out`.
- `cpu_wr`  in  1  core writes `write_out` this cycle.
- `out_full`  out  1  output FIFO full; core stalls on an I/O write.
- `host_out_data`  out  WIDTH  head of output FIFO.
- `host_out_valid`  out  1  host_out_data valid.
- `host_out_ready`  in  1  host accepts host_out_data.
- `io_err`  out  2  sticky errors, present only with the macro: [0] underflow, [1] overflow.

## Operation
- Two independent FIFOs, each with DEPTH entries, wr/rd pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
- Input push: `host_in_valid && host_in_ready`.
- Input pop: `cpu_rd && !in_empty`.
- Output push: `cpu_wr && !out_full`.
- Output pop: `host_out_valid && host_out_ready`.
- `host_in_ready = (in_count != DEPTH)`. It does not depend on a same-cycle pop.
- `host_out_valid = (out_count != 0)`.
- Simultaneous push and pop on a non-empty, non-full FIFO: both occur and the count is unchanged.
- Push to an empty FIFO with a same-cycle pop: push occurs, pop is ignored (underflow).
- `cpu_rd` while empty: no state change; `read_in` stays 0.
- `cpu_wr` while full: word dropped, no state change. The core must honour `out_full`.
- `read_in` and `host_out_data` show the memory entry at the rd pointer, qualified by non-empty (0 otherwise).
- Reset clears pointers, counts and `io_err`. It does not clear memory contents.
- After reset: `read_in`=0, `in_empty`=1, `host_in_ready`=1, `out_full`=0, `host_out_valid`=0, `host_out_data`=0, `io_err`=0.
- Reset asserted mid-transfer discards all buffered words. Handshakes in the reset cycle are ignored.

## Timing
- Pushed word becomes visible at the FIFO head on the cycle after the push edge. There is no bypass: minimum latency is 1 cycle in each direction.
- Status outputs (`in_empty`, `out_full`, `host_in_ready`, `host_out_valid`) are decoded from registered counts. They update one cycle after the causing edge.
- Throughput: one word per cycle per direction sustained. Both directions operate concurrently.
- The full FIFO drains in DEPTH cycles with `host_out_ready` held high.

## Configuration
- `IO_PORT_ERR_EN` defined:
  - `io_err` port exists.
  - Bit 0 sets on `cpu_rd && in_empty`.
  - Bit 1 sets on `cpu_wr && out_full`.
  - Both bits are sticky until `rst`.
- Not defined: `io_err` and its logic are absent, and error cases are silent drops/ignores as above.

## Structure
- Package `io_port_pkg`: `IO_WIDTH`=16, `IO_DEPTH`=4, `IO_PTR_W`=$clog2(IO_DEPTH), typedef `io_word_t`, error-bit index constants `IO_ERR_UNDER`=0, `IO_ERR_OVER`=1.
- Sub-module `io_fifo_component`:
  - Ports: push, push_data, pop, head, empty, full.
  - Parameterised by WIDTH/DEPTH.
  - Instantiated twice; the top adds handshake decode and error flags.

## Test plan
- Reset, then idle: `in_empty`=1, `host_in_ready`=1, `read_in`=0, `host_out_valid`=0.
- Host pushes 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles with no `cpu_rd`:
  - `host_in_ready` drops to 0 the cycle after the 4th push.
  - `read_in`=0x1111.
  - Four `cpu_rd` pulses yield 0x1111..0x4444 in order, then `in_empty`=1.
- Core pulses `cpu_wr` with 0xA0A0, 0xB0B0 while `host_out_ready`=0:
  - `host_out_valid`=1, `host_out_data`=0xA0A0 held stable.
  - Raising ready delivers 0xA0A0 then 0xB0B0 on successive cycles.
- Wrap-around: stream 10 words 0x0001..0x000A through the input FIFO with a simultaneous push/pop every cycle → all 10 read back in order, with the count steady at 1.
- With `IO_PORT_ERR_EN`:
  - `cpu_rd` on empty → `io_err`=2'b01.
  - Fill the output FIFO and pulse `cpu_wr` 0xDEAD → `io_err`=2'b11, and 0xDEAD is never delivered to the host.
  - `rst` returns `io_err` to 0.
- Reset mid-operation with 3 words in each FIFO → next cycle both FIFOs are empty and all status outputs are at reset values.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared constants and types for the host-side I/O port.
package io_port_pkg;
  localparam int IO_WIDTH     = 16;
  localparam int IO_DEPTH     = 4;
  localparam int IO_PTR_W     = $clog2(IO_DEPTH);
  typedef logic [IO_WIDTH-1:0] io_word_t;
  localparam int IO_ERR_UNDER = 0;
  localparam int IO_ERR_OVER  = 1;
endpackage

// File: rtl/io_fifo_component.sv
// Single-clock FIFO with a registered count. The head is qualified by
// non-empty and there is no push-to-head bypass.
// A push while full and a pop while empty are ignored.
module io_fifo_component
  import io_port_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and count next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  // Control state register; reset discards buffered words by clearing the count.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are left untouched by reset (head is masked when empty).
  always_ff @(posedge clock) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/io_port_component.sv
// Host-side I/O port: input FIFO (host -> core read_in) and output FIFO
// (core write_out -> host) with status for core stalls.
// Optional sticky error flags are enabled with the IO_PORT_ERR_EN macro.
module io_port_component
  import io_port_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic [WIDTH-1:0] read_in,
  input  logic             cpu_rd,
  output logic             in_empty,
  input  logic [WIDTH-1:0] write_out,
  input  logic             cpu_wr,
  output logic             out_full,
  output logic [WIDTH-1:0] host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready
`ifdef IO_PORT_ERR_EN
  ,
  output logic [1:0]       io_err
`endif
);
  logic in_full, out_empty;

  assign host_in_ready  = !in_full;
  assign host_out_valid = !out_empty;

  io_fifo_component #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clock     (clock),
    .rst       (rst),
    .push      (host_in_valid && host_in_ready),
    .push_data (host_in_data),
    .pop       (cpu_rd && !in_empty),
    .head      (read_in),
    .empty     (in_empty),
    .full      (in_full)
  );

  io_fifo_component #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clock     (clock),
    .rst       (rst),
    .push      (cpu_wr && !out_full),
    .push_data (write_out),
    .pop       (host_out_valid && host_out_ready),
    .head      (host_out_data),
    .empty     (out_empty),
    .full      (out_full)
  );

`ifdef IO_PORT_ERR_EN
  logic [1:0] io_err_q, io_err_d;

  // Sticky flags: core read while empty, core write while full.
  always_comb begin
    io_err_d = io_err_q;
    if (cpu_rd && in_empty) io_err_d[IO_ERR_UNDER] = 1'b1;
    if (cpu_wr && out_full) io_err_d[IO_ERR_OVER]  = 1'b1;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clock) begin
    if (rst) io_err_q <= '0;
    else     io_err_q <= io_err_d;
  end

  assign io_err = io_err_q;
`endif
endmodule
